// File: rtl/ifetch_ost.sv
// ifetch_ost -- instruction fetch outstanding-request tracker.
//
// Sits between the PC generator and the instruction bus. It issues fetch
// addresses while credit remains and remembers every in-flight address in
// a pending FIFO. Responses return in request order and are paired with
// their PC into a result FIFO that feeds the instruction queue. A flush
// turns every in-flight request into a "stale" one whose response is
// dropped when it eventually returns. Stale requests still hold a credit
// slot, so the bus never carries more than OST live-or-dead requests plus
// buffered results.
//
// Optional feature (macro IFETCH_BYPASS_EN): when the result FIFO is empty,
// a live response is forwarded to the fetch outputs in the same cycle. It
// is consumed without a FIFO write when fetch_ready is high.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   fetch_addr_*      address handshake from pcGen
//   ifu_mstReq_*      bus request channel, with ifu_addr
//   ifu_slvRsp_valid  in-order bus response, with ifu_data_r
//   fetch_pc/instr    head result to the instruction queue
//   fetch_valid/ready head result handshake
//   flush             discard all pending and buffered fetches
module ifetch_ost #(
    parameter int              DW     = 64,
    parameter int              AW     = 64,
    parameter int              OST    = 4,
    parameter logic [AW-1:0]   RST_PC = 64'h80000000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] fetch_addr_qout,
    input  logic          fetch_addr_valid,
    output logic          fetch_addr_ready,
    output logic          ifu_mstReq_valid,
    input  logic          ifu_mstReq_ready,
    output logic [AW-1:0] ifu_addr,
    input  logic          ifu_slvRsp_valid,
    input  logic [DW-1:0] ifu_data_r,
    output logic [AW-1:0] fetch_pc,
    output logic [DW-1:0] fetch_instr,
    output logic          fetch_valid,
    input  logic          fetch_ready,
    input  logic          flush
);
    localparam int PW = $clog2(OST);
    localparam int CW = $clog2(OST) + 1;
    localparam logic [CW+1:0] OST_LIM = (CW+2)'(OST);

    logic [CW-1:0] inflight, stale, used;
    logic [PW-1:0] pend_wp, pend_rp, res_wp, res_rp;
    logic [AW-1:0] pend_mem  [OST];
    logic [AW-1:0] res_pc    [OST];
    logic [DW-1:0] res_instr [OST];

    logic [CW+1:0] occ;
    logic          credit, issue;
    logic          rsp_any, rsp_stale, rsp_live;
    logic          head_valid, byp, res_push, res_pop;

    // Stale requests occupy credit until their responses drain.
    assign occ    = {2'b00, inflight} + {2'b00, stale} + {2'b00, used};
    assign credit = occ < OST_LIM;

    assign ifu_mstReq_valid = fetch_addr_valid & credit & ~flush & ~RST;
    assign ifu_addr         = fetch_addr_qout;
    assign fetch_addr_ready = ifu_mstReq_valid & ifu_mstReq_ready;
    assign issue            = fetch_addr_ready;

    // Stale responses are the oldest ones on the bus, so they retire first.
    // A response in a flush cycle counts as retired but is never delivered.
    assign rsp_any   = ifu_slvRsp_valid & ((stale != '0) | (inflight != '0));
    assign rsp_stale = ifu_slvRsp_valid & (stale != '0);
    assign rsp_live  = ifu_slvRsp_valid & (stale == '0) & (inflight != '0) & ~flush;

    assign head_valid = (used != '0);

`ifdef IFETCH_BYPASS_EN
    assign byp = rsp_live & ~head_valid;
`else
    assign byp = 1'b0;
`endif

    assign fetch_valid = (head_valid | byp) & ~RST;
    assign fetch_pc    = head_valid ? res_pc[res_rp]    :
                         byp        ? pend_mem[pend_rp] : RST_PC;
    assign fetch_instr = head_valid ? res_instr[res_rp] :
                         byp        ? ifu_data_r        : '0;

    assign res_pop  = head_valid & fetch_ready;
    // A bypassed response taken this cycle never touches the FIFO.
    assign res_push = rsp_live & ~(byp & fetch_ready);

    // Control state: counters and pointers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight <= '0;
            stale    <= '0;
            used     <= '0;
            pend_wp  <= '0;
            pend_rp  <= '0;
            res_wp   <= '0;
            res_rp   <= '0;
        end else if (flush) begin
            stale    <= stale + inflight - CW'(rsp_any);
            inflight <= '0;
            used     <= '0;
            pend_wp  <= '0;
            pend_rp  <= '0;
            res_wp   <= '0;
            res_rp   <= '0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(rsp_live);
            stale    <= stale - CW'(rsp_stale);
            used     <= used + CW'(res_push) - CW'(res_pop);
            if (issue)    pend_wp <= pend_wp + PW'(1);
            if (rsp_live) pend_rp <= pend_rp + PW'(1);
            if (res_push) res_wp  <= res_wp + PW'(1);
            if (res_pop)  res_rp  <= res_rp + PW'(1);
        end
    end

    // Storage: no reset needed, validity is tracked by the counters.
    // issue and rsp_live are both low during flush, so no stray writes.
    always_ff @(posedge CLK) begin
        if (issue) pend_mem[pend_wp] <= ifu_addr;
        if (res_push) begin
            res_pc[res_wp]    <= pend_mem[pend_rp];
            res_instr[res_wp] <= ifu_data_r;
        end
    end

endmodule

// File: tb/tb_ifetch_ost.sv
module tb_ifetch_ost;
    localparam int DW  = 64;
    localparam int AW  = 64;
    localparam int OST = 4;
    localparam logic [63:0] RPC = 64'h80000000;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] fetch_addr_qout;
    logic          fetch_addr_valid, fetch_addr_ready;
    logic          ifu_mstReq_valid, ifu_mstReq_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_slvRsp_valid;
    logic [DW-1:0] ifu_data_r;
    logic [AW-1:0] fetch_pc;
    logic [DW-1:0] fetch_instr;
    logic          fetch_valid, fetch_ready, flush;

    ifetch_ost #(.DW(DW), .AW(AW), .OST(OST), .RST_PC(RPC)) dut (
        .CLK(CLK), .RST(RST),
        .fetch_addr_qout(fetch_addr_qout), .fetch_addr_valid(fetch_addr_valid),
        .fetch_addr_ready(fetch_addr_ready),
        .ifu_mstReq_valid(ifu_mstReq_valid), .ifu_mstReq_ready(ifu_mstReq_ready),
        .ifu_addr(ifu_addr),
        .ifu_slvRsp_valid(ifu_slvRsp_valid), .ifu_data_r(ifu_data_r),
        .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .flush(flush)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          av;
        logic [63:0] addr;
        bit          brdy;
        bit          rsp;
        logic [63:0] data;
        bit          frdy;
        bit          fl;
        bit          use_tbl;
        bit          e_ar;
        bit          e_fv;
    } vec_t;

    typedef struct { logic [63:0] addr; bit live; } bus_t;
    typedef struct { logic [63:0] pc; logic [63:0] instr; } res_t;

    bus_t bus_q[$];   // requests on the bus, oldest first
    res_t exp_q[$];   // scoreboard of results the DUT must deliver
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t V(bit av, logic [63:0] a, bit rsp, logic [63:0] d,
                               bit frdy, bit fl, bit e_ar, bit e_fv);
        vec_t v;
        v.av = av; v.addr = a; v.brdy = 1'b1; v.rsp = rsp; v.data = d;
        v.frdy = frdy; v.fl = fl; v.use_tbl = 1'b1; v.e_ar = e_ar; v.e_fv = e_fv;
        return v;
    endfunction

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cyc(input vec_t v);
        int   cnt;
        bit   e_mv, e_ar, e_fv, live;
        bus_t b;
        res_t r;
        fetch_addr_valid = v.av;  fetch_addr_qout = v.addr;
        ifu_mstReq_ready = v.brdy; ifu_slvRsp_valid = v.rsp;
        ifu_data_r = v.data; fetch_ready = v.frdy; flush = v.fl;
        #1;
        cnt  = bus_q.size() + exp_q.size();
        e_mv = v.av && !v.fl && (cnt < OST);
        e_ar = e_mv && v.brdy;
        live = v.rsp && (bus_q.size() > 0) && bus_q[0].live && !v.fl;
        e_fv = (exp_q.size() > 0) || (BYP && live);
        chk("mstReq_valid", {63'd0, ifu_mstReq_valid}, {63'd0, e_mv});
        chk("addr_ready", {63'd0, fetch_addr_ready}, {63'd0, e_ar});
        chk("fetch_valid", {63'd0, fetch_valid}, {63'd0, e_fv});
        if (v.use_tbl && !BYP) begin
            chk("tbl_addr_ready", {63'd0, fetch_addr_ready}, {63'd0, v.e_ar});
            chk("tbl_fetch_valid", {63'd0, fetch_valid}, {63'd0, v.e_fv});
        end
        if (e_mv) chk("ifu_addr", ifu_addr, v.addr);
        if (v.rsp && bus_q.size() > 0) begin
            b = bus_q.pop_front();
            if (live) begin
                r.pc = b.addr; r.instr = v.data;
                exp_q.push_back(r);
            end
        end
        if (e_fv && exp_q.size() > 0) begin
            chk("fetch_pc", fetch_pc, exp_q[0].pc);
            chk("fetch_instr", fetch_instr, exp_q[0].instr);
            if (v.frdy) void'(exp_q.pop_front());
        end
        if (e_ar) begin
            b.addr = v.addr; b.live = 1'b1;
            bus_q.push_back(b);
        end
        if (v.fl) begin
            foreach (bus_q[i]) bus_q[i].live = 1'b0;
            exp_q.delete();
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vec_t        v;
        logic [63:0] pc;
        RST = 1'b1; flush = 1'b0; fetch_ready = 1'b0;
        fetch_addr_valid = 1'b1; fetch_addr_qout = RPC;
        ifu_mstReq_ready = 1'b1; ifu_slvRsp_valid = 1'b0; ifu_data_r = '0;
        #1;
        chk("rst_mstReq_valid", {63'd0, ifu_mstReq_valid}, 64'd0);
        chk("rst_addr_ready", {63'd0, fetch_addr_ready}, 64'd0);
        @(posedge CLK); @(posedge CLK); #1;
        chk("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        chk("rst_fetch_pc", fetch_pc, RPC);
        chk("rst_fetch_instr", fetch_instr, 64'd0);
        RST = 1'b0; fetch_addr_valid = 1'b0;
        #1;
        chk("post_rst_fetch_pc", fetch_pc, RPC);
        @(posedge CLK); #1;

        //          av  addr          rsp data     frdy fl  ar  fv
        // first fetch: one-cycle response, one-cycle delivery
        tbl.push_back(V(1, 64'h80000000, 0, 0,        0, 0, 1, 0));
        tbl.push_back(V(0, 0,            1, 64'h13,   0, 0, 0, 0));
        tbl.push_back(V(0, 0,            0, 0,        0, 0, 0, 1));
        tbl.push_back(V(0, 0,            0, 0,        1, 0, 0, 1));
        tbl.push_back(V(0, 0,            1, 64'hbad,  0, 0, 0, 0));
        // fill to OST with fetch_ready low, fifth address stalls until a pop
        tbl.push_back(V(1, 64'h1000,     0, 0,        0, 0, 1, 0));
        tbl.push_back(V(1, 64'h1004,     1, 64'ha0,   0, 0, 1, 0));
        tbl.push_back(V(1, 64'h1008,     1, 64'ha1,   0, 0, 1, 1));
        tbl.push_back(V(1, 64'h100c,     1, 64'ha2,   0, 0, 1, 1));
        tbl.push_back(V(1, 64'h1010,     1, 64'ha3,   0, 0, 0, 1));
        tbl.push_back(V(1, 64'h1010,     0, 0,        0, 0, 0, 1));
        tbl.push_back(V(1, 64'h1010,     0, 0,        1, 0, 0, 1));
        tbl.push_back(V(1, 64'h1010,     0, 0,        0, 0, 1, 1));
        tbl.push_back(V(0, 0,            1, 64'ha4,   1, 0, 0, 1));
        tbl.push_back(V(0, 0,            0, 0,        1, 0, 0, 1));
        tbl.push_back(V(0, 0,            0, 0,        1, 0, 0, 1));
        tbl.push_back(V(0, 0,            0, 0,        1, 0, 0, 1));
        tbl.push_back(V(0, 0,            1, 64'hbad,  0, 0, 0, 0));
        // three in flight, flush, stale responses then one live fetch
        tbl.push_back(V(1, 64'h2000,     0, 0,        0, 0, 1, 0));
        tbl.push_back(V(1, 64'h2004,     0, 0,        0, 0, 1, 0));
        tbl.push_back(V(1, 64'h2008,     0, 0,        0, 0, 1, 0));
        tbl.push_back(V(1, 64'h200c,     0, 0,        0, 1, 0, 0));
        tbl.push_back(V(1, 64'h80001000, 1, 64'hd0,   0, 0, 1, 0));
        tbl.push_back(V(0, 0,            1, 64'hd1,   0, 0, 0, 0));
        tbl.push_back(V(0, 0,            1, 64'hd2,   0, 0, 0, 0));
        tbl.push_back(V(0, 0,            1, 64'h1234, 0, 0, 0, 0));
        tbl.push_back(V(0, 0,            0, 0,        1, 0, 0, 1));
        tbl.push_back(V(0, 0,            0, 0,        0, 0, 0, 0));
        // response and flush together with two in flight
        tbl.push_back(V(1, 64'h3000,     0, 0,        0, 0, 1, 0));
        tbl.push_back(V(1, 64'h3004,     0, 0,        0, 0, 1, 0));
        tbl.push_back(V(0, 0,            1, 64'he0,   0, 1, 0, 0));
        tbl.push_back(V(1, 64'h3008,     1, 64'he1,   0, 0, 1, 0));
        tbl.push_back(V(0, 0,            0, 0,        0, 0, 0, 0));
        tbl.push_back(V(0, 0,            1, 64'h55,   0, 0, 0, 0));
        tbl.push_back(V(0, 0,            0, 0,        1, 0, 0, 1));
        tbl.push_back(V(0, 0,            0, 0,        0, 0, 0, 0));
        // flush drops a buffered result
        tbl.push_back(V(1, 64'h4000,     0, 0,        0, 0, 1, 0));
        tbl.push_back(V(0, 0,            1, 64'h66,   0, 0, 0, 0));
        tbl.push_back(V(0, 0,            0, 0,        0, 0, 0, 1));
        tbl.push_back(V(0, 0,            0, 0,        0, 1, 0, 1));
        tbl.push_back(V(0, 0,            0, 0,        0, 0, 0, 0));
        // response with fetch_ready high into an empty result FIFO
        tbl.push_back(V(1, 64'h5000,     0, 0,        1, 0, 1, 0));
        tbl.push_back(V(0, 0,            1, 64'h00100093, 1, 0, 0, 0));
        tbl.push_back(V(0, 0,            0, 0,        1, 0, 0, 1));
        tbl.push_back(V(0, 0,            0, 0,        1, 0, 0, 0));

        foreach (tbl[i]) cyc(tbl[i]);

        // Random traffic: back-pressure, overlapping issue/response,
        // occasional flushes; order is checked by the scoreboard.
        pc = 64'h80002000;
        for (int n = 0; n < 300; n++) begin
            v.av = ($urandom_range(0, 3) != 0); v.addr = pc; pc = pc + 64'd4;
            v.brdy = ($urandom_range(0, 3) != 0);
            v.rsp  = ($urandom_range(0, 2) != 0);
            v.data = {$urandom, $urandom};
            v.frdy = ($urandom_range(0, 2) != 0);
            v.fl   = ($urandom_range(0, 24) == 0);
            v.use_tbl = 1'b0; v.e_ar = 1'b0; v.e_fv = 1'b0;
            cyc(v);
        end
        // Drain everything.
        for (int n = 0; n < 20; n++) begin
            v.av = 1'b0; v.addr = '0; v.brdy = 1'b1; v.rsp = 1'b1;
            v.data = {$urandom, $urandom}; v.frdy = 1'b1; v.fl = 1'b0;
            v.use_tbl = 1'b0; v.e_ar = 1'b0; v.e_fv = 1'b0;
            cyc(v);
        end
        chk("drain_results_left", 64'(exp_q.size()), 64'd0);
        chk("drain_fetch_valid", {63'd0, fetch_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
